fir_mem_ctrl: RTL and testbench

Sequencer for the FIR shared sample/coefficient memory. It accepts one input sample per handshake and writes it into a circular delay-line region of the memory. It then walks `NUM_TAPS` paired reads: samples newest-to-oldest and coefficients tap 0 upward. It emits MAC control strobes aligned to the memory's 2-cycle read latency, and sits between the sample source and the `memory` + DSP58 MAC datapath.

---
 rtl/fir_mem_ctrl.sv | 130 +++++++++++++
 tb/tb_fir_mem_ctrl.sv | 340 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fir_mem_ctrl.sv
// fir_mem_ctrl: FIR sample/coefficient memory sequencer with 2-cycle-aligned MAC strobes; FIR_CTRL_CLEAR_EN adds clear_i and a CLEAR state
module fir_mem_ctrl #(
   parameter int DATA_WIDTH    = 32,
   parameter int ADDRESS_WIDTH = 3,
   parameter int NUM_TAPS      = 4,
   parameter int X_BASE        = 0,
   parameter int H_BASE        = 4
) (
   input  logic                     clk_i,
   input  logic                     rst_ni,
`ifdef FIR_CTRL_CLEAR_EN
   input  logic                     clear_i,
`endif
   input  logic [DATA_WIDTH-1:0]    sample_i,
   input  logic                     sample_valid_i,
   output logic                     sample_ready_o,
   output logic                     mem_en_x_o,
   output logic                     mem_we_x_o,
   output logic [ADDRESS_WIDTH-1:0] mem_addr_x_o,
   output logic [DATA_WIDTH-1:0]    mem_x_o,
   output logic                     mem_en_h_o,
   output logic                     mem_we_h_o,
   output logic [ADDRESS_WIDTH-1:0] mem_addr_h_o,
   output logic                     mac_en_o,
   output logic                     mac_first_o,
   output logic                     mac_last_o,
   output logic                     done_o,
   output logic                     busy_o
);
   localparam int PW = $clog2(NUM_TAPS);
   localparam logic [PW-1:0] LAST = PW'(NUM_TAPS - 1);
   localparam logic [ADDRESS_WIDTH-1:0] XB = ADDRESS_WIDTH'(X_BASE);
   localparam logic [ADDRESS_WIDTH-1:0] HB = ADDRESS_WIDTH'(H_BASE);
   typedef enum logic [2:0] {
      IDLE, WRITE, RUN, DRAIN, DONE
`ifdef FIR_CTRL_CLEAR_EN
      , CLEAR
`endif
   } state_t;
   state_t state;
   logic [PW-1:0] wptr, rptr, k, rptr_dec;
   logic [1:0] vld, fst, lst;
   logic issue, clr_st;
`ifdef FIR_CTRL_CLEAR_EN
   assign clr_st = state == CLEAR;
   assign sample_ready_o = state == IDLE && !clear_i;
`else
   assign clr_st = 1'b0;
   assign sample_ready_o = state == IDLE;
`endif
   always_comb begin
      issue = state == WRITE || state == RUN;
      rptr_dec = rptr == '0 ? LAST : rptr - 1'b1;
      mem_en_x_o = issue || clr_st;
      mem_we_x_o = state == WRITE || clr_st;
      mem_addr_x_o = mem_en_x_o ? XB + ADDRESS_WIDTH'(clr_st ? k : rptr) : '0;
      mem_en_h_o = issue;
      mem_we_h_o = 1'b0;
      mem_addr_h_o = issue ? HB + ADDRESS_WIDTH'(k) : '0;
      busy_o = state != IDLE;
      mac_en_o = vld[1];
      mac_first_o = fst[1];
      mac_last_o = lst[1];
   end
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state <= IDLE;
         wptr <= '0;
         rptr <= '0;
         k <= '0;
         vld <= '0;
         fst <= '0;
         lst <= '0;
         done_o <= 1'b0;
         mem_x_o <= '0;
      end else begin
         vld <= {vld[0], issue};
         fst <= {fst[0], state == WRITE};
         lst <= {lst[0], state == RUN && k == LAST};
         done_o <= lst[1];
         case (state)
            IDLE:
`ifdef FIR_CTRL_CLEAR_EN
               if (clear_i) begin
                  mem_x_o <= '0;
                  k <= '0;
                  state <= CLEAR;
               end else
`endif
               if (sample_valid_i) begin
                  mem_x_o <= sample_i;
                  rptr <= wptr;
                  k <= '0;
                  state <= WRITE;
               end
            WRITE: begin
               rptr <= rptr_dec;
               k <= k + 1'b1;
               state <= RUN;
            end
            RUN:
               if (k == LAST) begin
                  k <= '0;
                  state <= DRAIN;
               end else begin
                  k <= k + 1'b1;
                  rptr <= rptr_dec;
               end
            DRAIN:
               if (k == PW'(1)) begin
                  k <= '0;
                  state <= DONE;
               end else k <= k + 1'b1;
            DONE: begin
               wptr <= wptr == LAST ? '0 : wptr + 1'b1;
               state <= IDLE;
            end
`ifdef FIR_CTRL_CLEAR_EN
            CLEAR:
               if (k == LAST) begin
                  k <= '0;
                  wptr <= '0;
                  state <= IDLE;
               end else k <= k + 1'b1;
`endif
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_fir_mem_ctrl.sv
// tb_fir_mem_ctrl: directed self-checking bench for fir_mem_ctrl with a 2-cycle write-through memory model
module tb_fir_mem_ctrl;
   localparam int DW = 32;
   localparam int AW = 3;
   localparam int N = 4;
   logic clk_i = 1'b0;
   logic rst_ni = 1'b0;
`ifdef FIR_CTRL_CLEAR_EN
   logic clear_i = 1'b0;
`endif
   logic [DW-1:0] sample_i = '0;
   logic sample_valid_i = 1'b0;
   logic sample_ready_o, mem_en_x_o, mem_we_x_o, mem_en_h_o, mem_we_h_o;
   logic [AW-1:0] mem_addr_x_o, mem_addr_h_o;
   logic [DW-1:0] mem_x_o;
   logic mac_en_o, mac_first_o, mac_last_o, done_o, busy_o;
   logic [DW-1:0] mem [0:7];
   logic [DW-1:0] x1, x2, h1, h2;
   logic init_mem = 1'b0;
   int checks = 0;
   int errors = 0;
   logic [AW-1:0] o_ax [8];
   logic [AW-1:0] o_ah [8];
   logic [DW-1:0] o_x [8];
   logic [DW-1:0] o_h [8];
   logic o_enx [8];
   logic o_wex [8];
   logic o_me [8];
   logic o_mf [8];
   logic o_ml [8];
   logic o_dn [8];
   logic o_rdy [8];
   logic o_bz [8];

   always #5 clk_i = ~clk_i;

   fir_mem_ctrl #(.DATA_WIDTH(DW), .ADDRESS_WIDTH(AW), .NUM_TAPS(N), .X_BASE(0), .H_BASE(4)) dut (
      .clk_i(clk_i),
      .rst_ni(rst_ni),
`ifdef FIR_CTRL_CLEAR_EN
      .clear_i(clear_i),
`endif
      .sample_i(sample_i),
      .sample_valid_i(sample_valid_i),
      .sample_ready_o(sample_ready_o),
      .mem_en_x_o(mem_en_x_o),
      .mem_we_x_o(mem_we_x_o),
      .mem_addr_x_o(mem_addr_x_o),
      .mem_x_o(mem_x_o),
      .mem_en_h_o(mem_en_h_o),
      .mem_we_h_o(mem_we_h_o),
      .mem_addr_h_o(mem_addr_h_o),
      .mac_en_o(mac_en_o),
      .mac_first_o(mac_first_o),
      .mac_last_o(mac_last_o),
      .done_o(done_o),
      .busy_o(busy_o)
   );

   always @(posedge clk_i) begin
      if (init_mem) begin
         for (int i = 0; i < 8; i++) mem[i] <= (i >= 4) ? DW'(i - 3) : '0;
      end else begin
         if (mem_en_x_o && mem_we_x_o) mem[mem_addr_x_o] <= mem_x_o;
         if (mem_en_h_o && mem_we_h_o) mem[mem_addr_h_o] <= '0;
      end
      if (mem_en_x_o) x1 <= mem_we_x_o ? mem_x_o : mem[mem_addr_x_o];
      if (mem_en_h_o) h1 <= mem_we_h_o ? '0 : mem[mem_addr_h_o];
      x2 <= x1;
      h2 <= h1;
   end

   task automatic reset_dut();
      rst_ni = 1'b0;
      init_mem = 1'b1;
      sample_valid_i = 1'b0;
`ifdef FIR_CTRL_CLEAR_EN
      clear_i = 1'b0;
`endif
      @(posedge clk_i);
      @(posedge clk_i);
      #1;
      init_mem = 1'b0;
      rst_ni = 1'b1;
   endtask

   task automatic send(input logic [DW-1:0] d);
      sample_valid_i = 1'b1;
      sample_i = d;
      for (int c = 0; c < 8; c++) begin
         @(negedge clk_i);
         o_ax[c] = mem_addr_x_o;
         o_ah[c] = mem_addr_h_o;
         o_x[c] = x2;
         o_h[c] = h2;
         o_enx[c] = mem_en_x_o;
         o_wex[c] = mem_we_x_o;
         o_me[c] = mac_en_o;
         o_mf[c] = mac_first_o;
         o_ml[c] = mac_last_o;
         o_dn[c] = done_o;
         o_rdy[c] = sample_ready_o;
         o_bz[c] = busy_o;
         @(posedge clk_i);
         #1;
         sample_valid_i = 1'b0;
      end
   endtask

   task automatic test_reset();
      rst_ni = 1'b0;
      @(negedge clk_i);
      checks++;
      if (sample_ready_o !== 1'b1) begin
         errors++;
         $display("FAIL reset_ready got %b want 1", sample_ready_o);
      end
      checks++;
      if (busy_o !== 1'b0) begin
         errors++;
         $display("FAIL reset_busy got %b want 0", busy_o);
      end
      checks++;
      if ({mem_en_x_o, mem_we_x_o, mem_addr_x_o, mem_x_o, mem_en_h_o, mem_we_h_o, mem_addr_h_o,
           mac_en_o, mac_first_o, mac_last_o, done_o} !== '0) begin
         errors++;
         $display("FAIL reset_outputs got en_x=%b we_x=%b ax=%0d x=%0h en_h=%b we_h=%b ah=%0d mac=%b%b%b done=%b want all 0",
                  mem_en_x_o, mem_we_x_o, mem_addr_x_o, mem_x_o, mem_en_h_o, mem_we_h_o, mem_addr_h_o,
                  mac_en_o, mac_first_o, mac_last_o, done_o);
      end
   endtask

   task automatic test_single();
      logic [AW-1:0] eax [4];
      logic [DW-1:0] ex [4];
      eax = '{3'd0, 3'd3, 3'd2, 3'd1};
      ex = '{32'h5, 32'h0, 32'h0, 32'h0};
      reset_dut();
      send(32'h5);
      for (int c = 1; c <= 4; c++) begin
         checks++;
         if (o_ax[c] !== eax[c-1] || o_ah[c] !== AW'(c + 3) || o_enx[c] !== 1'b1 || o_wex[c] !== (c == 1)) begin
            errors++;
            $display("FAIL single_addr c=%0d got ax=%0d ah=%0d en=%b we=%b want ax=%0d ah=%0d en=1 we=%b",
                     c, o_ax[c], o_ah[c], o_enx[c], o_wex[c], eax[c-1], c + 3, c == 1);
         end
      end
      for (int c = 0; c < 8; c++) begin
         checks++;
         if (o_me[c] !== (c >= 3 && c <= 6) || o_mf[c] !== (c == 3) || o_ml[c] !== (c == 6) ||
             o_dn[c] !== (c == 7) || o_rdy[c] !== (c == 0) || o_bz[c] !== (c != 0)) begin
            errors++;
            $display("FAIL single_strobes c=%0d got en=%b first=%b last=%b done=%b rdy=%b busy=%b want %b %b %b %b %b %b",
                     c, o_me[c], o_mf[c], o_ml[c], o_dn[c], o_rdy[c], o_bz[c],
                     c >= 3 && c <= 6, c == 3, c == 6, c == 7, c == 0, c != 0);
         end
      end
      for (int c = 3; c <= 6; c++) begin
         checks++;
         if (o_x[c] !== ex[c-3] || o_h[c] !== DW'(c - 2)) begin
            errors++;
            $display("FAIL single_data c=%0d got x=%0h h=%0h want x=%0h h=%0h", c, o_x[c], o_h[c], ex[c-3], c - 2);
         end
      end
      @(negedge clk_i);
      checks++;
      if (sample_ready_o !== 1'b1 || busy_o !== 1'b0) begin
         errors++;
         $display("FAIL single_ready8 got rdy=%b busy=%b want rdy=1 busy=0", sample_ready_o, busy_o);
      end
   endtask

   task automatic test_back_to_back();
      logic [AW-1:0] eax [4];
      eax = '{3'd0, 3'd3, 3'd2, 3'd1};
      reset_dut();
      for (int s = 1; s <= 4; s++) begin
         send(DW'(s));
         checks++;
         if (o_ax[1] !== AW'(s - 1) || o_rdy[0] !== 1'b1) begin
            errors++;
            $display("FAIL b2b_wptr s=%0d got ax=%0d rdy=%b want ax=%0d rdy=1", s, o_ax[1], o_rdy[0], s - 1);
         end
      end
      send(32'h5);
      for (int c = 1; c <= 4; c++) begin
         checks++;
         if (o_ax[c] !== eax[c-1] || o_ah[c] !== AW'(c + 3)) begin
            errors++;
            $display("FAIL b2b_addr c=%0d got ax=%0d ah=%0d want ax=%0d ah=%0d", c, o_ax[c], o_ah[c], eax[c-1], c + 3);
         end
      end
      for (int c = 3; c <= 6; c++) begin
         checks++;
         if (o_me[c] !== 1'b1 || o_x[c] !== DW'(8 - c) || o_h[c] !== DW'(c - 2)) begin
            errors++;
            $display("FAIL b2b_data c=%0d got en=%b x=%0h h=%0h want en=1 x=%0h h=%0h", c, o_me[c], o_x[c], o_h[c], 8 - c, c - 2);
         end
      end
      send(32'h6);
      checks++;
      if (o_ax[1] !== 3'd1 || o_ax[2] !== 3'd0 || o_x[3] !== 32'h6 || o_x[4] !== 32'h5) begin
         errors++;
         $display("FAIL b2b_wrap got ax1=%0d ax2=%0d x3=%0h x4=%0h want 1 0 6 5", o_ax[1], o_ax[2], o_x[3], o_x[4]);
      end
   endtask

   task automatic test_valid_held();
      reset_dut();
      sample_valid_i = 1'b1;
      sample_i = 32'hA;
      for (int c = 0; c <= 8; c++) begin
         @(negedge clk_i);
         checks++;
         if (sample_ready_o !== (c == 0 || c == 8)) begin
            errors++;
            $display("FAIL held_ready c=%0d got %b want %b", c, sample_ready_o, c == 0 || c == 8);
         end
         if (c == 1) begin
            checks++;
            if (mem_x_o !== 32'hA || mem_we_x_o !== 1'b1) begin
               errors++;
               $display("FAIL held_wdata1 got x=%0h we=%b want x=a we=1", mem_x_o, mem_we_x_o);
            end
         end
         if (c == 3) begin
            checks++;
            if (mac_en_o !== 1'b1 || x2 !== 32'hA) begin
               errors++;
               $display("FAIL held_mac got en=%b x=%0h want en=1 x=a", mac_en_o, x2);
            end
         end
         @(posedge clk_i);
         #1;
         sample_i = DW'(32'hB0 + c);
      end
      sample_valid_i = 1'b0;
      @(negedge clk_i);
      checks++;
      if (mem_we_x_o !== 1'b1 || mem_addr_x_o !== 3'd1 || mem_x_o !== 32'hB7) begin
         errors++;
         $display("FAIL held_second got we=%b ax=%0d x=%0h want we=1 ax=1 x=b7", mem_we_x_o, mem_addr_x_o, mem_x_o);
      end
   endtask

   task automatic test_reset_mid();
      int pulses;
      reset_dut();
      sample_valid_i = 1'b1;
      sample_i = 32'h9;
      for (int c = 0; c < 3; c++) begin
         @(posedge clk_i);
         #1;
         sample_valid_i = 1'b0;
      end
      rst_ni = 1'b0;
      #1;
      checks++;
      if (busy_o !== 1'b0 || sample_ready_o !== 1'b1 || mac_en_o !== 1'b0 || mem_en_x_o !== 1'b0) begin
         errors++;
         $display("FAIL midrst_state got busy=%b rdy=%b mac=%b en_x=%b want 0 1 0 0", busy_o, sample_ready_o, mac_en_o, mem_en_x_o);
      end
      @(posedge clk_i);
      #1;
      rst_ni = 1'b1;
      pulses = 0;
      for (int c = 0; c < 10; c++) begin
         @(negedge clk_i);
         pulses += int'(mac_en_o) + int'(done_o);
      end
      checks++;
      if (pulses != 0) begin
         errors++;
         $display("FAIL midrst_pulses got %0d want 0", pulses);
      end
      @(posedge clk_i);
      #1;
      send(32'h6);
      checks++;
      if (o_ax[1] !== 3'd0 || o_x[3] !== 32'h6) begin
         errors++;
         $display("FAIL midrst_next got ax=%0d x=%0h want ax=0 x=6", o_ax[1], o_x[3]);
      end
   endtask

`ifdef FIR_CTRL_CLEAR_EN
   task automatic test_clear();
      reset_dut();
      for (int s = 1; s <= 3; s++) send(DW'(s));
      clear_i = 1'b1;
      sample_valid_i = 1'b1;
      sample_i = 32'h9;
      @(negedge clk_i);
      checks++;
      if (sample_ready_o !== 1'b0) begin
         errors++;
         $display("FAIL clear_ready got %b want 0", sample_ready_o);
      end
      @(posedge clk_i);
      #1;
      clear_i = 1'b0;
      sample_valid_i = 1'b0;
      for (int c = 1; c <= 5; c++) begin
         @(negedge clk_i);
         checks++;
         if (c <= 4 && (mem_en_x_o !== 1'b1 || mem_we_x_o !== 1'b1 || mem_addr_x_o !== AW'(c - 1) ||
             mem_x_o !== '0 || busy_o !== 1'b1 || mac_en_o !== 1'b0 || mem_en_h_o !== 1'b0)) begin
            errors++;
            $display("FAIL clear_walk c=%0d got en=%b we=%b ax=%0d x=%0h busy=%b mac=%b en_h=%b", c,
                     mem_en_x_o, mem_we_x_o, mem_addr_x_o, mem_x_o, busy_o, mac_en_o, mem_en_h_o);
         end
         if (c == 5 && (sample_ready_o !== 1'b1 || busy_o !== 1'b0)) begin
            errors++;
            $display("FAIL clear_idle got rdy=%b busy=%b want 1 0", sample_ready_o, busy_o);
         end
         @(posedge clk_i);
         #1;
      end
      send(32'h7);
      checks++;
      if (o_ax[1] !== 3'd0 || o_x[3] !== 32'h7 || o_x[4] !== '0 || o_x[5] !== '0 || o_x[6] !== '0) begin
         errors++;
         $display("FAIL clear_next got ax=%0d x=%0h,%0h,%0h,%0h want 0 7,0,0,0", o_ax[1], o_x[3], o_x[4], o_x[5], o_x[6]);
      end
   endtask
`endif

   initial begin
      test_reset();
      test_single();
      test_back_to_back();
      test_valid_held();
      test_reset_mid();
`ifdef FIR_CTRL_CLEAR_EN
      test_clear();
`endif
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
